// File: rtl/tsc_readout_if.sv
// tsc_readout_if
//   Bundles every non-clock, non-reset signal of tsc_readout.
//   TSC side : trd, trigtm, sd, cd (to the readout), sbf (to the TSC).
//   Host side: arm, frame_ack, rd_addr (to the readout);
//              frame_ready, trig_time, rd_data, err_short, err_timeout, busy
//              (from the readout).
//   modport slave  : the readout block itself.
//   modport master : whatever drives it (TSC model plus host).
interface tsc_readout_if #(
  parameter int BUF_BYTES = 32
);
  localparam int AW = $clog2(BUF_BYTES);

  logic          arm;
  logic          trd;
  logic [31:0]   trigtm;
  logic          sd;
  logic          cd;
  logic          sbf;
  logic          frame_ready;
  logic [31:0]   trig_time;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_ack;
  logic          err_short;
  logic          err_timeout;
  logic          busy;

  modport slave (
    input  arm, trd, trigtm, sd, cd, rd_addr, frame_ack,
    output sbf, frame_ready, trig_time, rd_data, err_short, err_timeout, busy
  );

  modport master (
    output arm, trd, trigtm, sd, cd, rd_addr, frame_ack,
    input  sbf, frame_ready, trig_time, rd_data, err_short, err_timeout, busy
  );
endinterface

// File: rtl/tsc_readout.sv
// tsc_readout
//   Captures one TSC frame per accepted trigger. On a trd rising edge while
//   armed, trigtm is latched and sbf is pulsed; the serial stream on sd is
//   then deserialised MSB-first into a byte buffer, and cd closes the frame.
//   The host reads bytes through a registered read port (1-cycle latency)
//   and releases the frame with frame_ack.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : tsc_readout_if.slave (TSC link, host control and read port)
module tsc_readout #(
  parameter int BUF_BYTES  = 32,
  parameter int START_LAT  = 2,
  parameter int CD_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  tsc_readout_if.slave bus
);
  localparam int AW = $clog2(BUF_BYTES);
  localparam int BW = $clog2(8 * BUF_BYTES);
  localparam int TW = $clog2(CD_TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(8 * BUF_BYTES - 1);
  localparam logic [3:0]    LAT_LOAD = 4'(START_LAT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(CD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ARMED, REQ, LAT, SHIFT, WAIT_CD, DONE
  } state_e;

  state_e        state_q, state_d;
  logic          trd_prev_q, trd_prev_d;
  logic [31:0]   trig_time_q, trig_time_d;
  logic [3:0]    lat_q, lat_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]    shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_short_q, err_short_d;
  logic          err_timeout_q, err_timeout_d;
  logic [7:0]    rd_data_q;

  logic          sbf;
  logic          busy;
  logic          frame_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  logic [7:0]    mem [BUF_BYTES];

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      trd_prev_q    <= 1'b1;  // a trd already high out of reset is not an edge
      trig_time_q   <= '0;
      lat_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      timer_q       <= '0;
      err_short_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trd_prev_q    <= trd_prev_d;
      trig_time_q   <= trig_time_d;
      lat_q         <= lat_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      timer_q       <= timer_d;
      err_short_q   <= err_short_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Frame buffer: write port has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, free-running in every state
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[bus.rd_addr];
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    trd_prev_d    = bus.trd;
    trig_time_d   = trig_time_q;
    lat_d         = lat_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    timer_d       = timer_q;
    err_short_d   = err_short_q;
    err_timeout_d = err_timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d       = ARMED;
          err_short_d   = 1'b0;
          err_timeout_d = 1'b0;
        end
      end

      ARMED: begin
        if (bus.trd && !trd_prev_q) begin
          trig_time_d = bus.trigtm;
          state_d     = REQ;
        end
      end

      REQ: begin
        // lat counts the LAT cycles still to spend; with START_LAT=1 the
        // first bit arrives right after REQ, so LAT is skipped entirely.
        lat_d     = LAT_LOAD;
        bit_cnt_d = '0;
        shift_d   = '0;
        state_d   = (START_LAT <= 1) ? SHIFT : LAT;
      end

      LAT: begin
        if (lat_q <= 4'd1) begin
          state_d = SHIFT;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      SHIFT: begin
        if (bus.cd) begin
          // Early end of frame: the partial byte in shift_q is dropped.
          err_short_d = 1'b1;
          state_d     = DONE;
        end else begin
          shift_d = {shift_q[5:0], bus.sd};
          if (bit_cnt_q == LAST_BIT) begin
            // timer holds cycles elapsed since the last bit
            timer_d = TW'(1);
            state_d = WAIT_CD;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      WAIT_CD: begin
        if (bus.cd) begin
          state_d = DONE;
        end else if (timer_q >= TMO_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      DONE: begin
        if (bus.frame_ack) begin
          if (bus.arm) begin
            state_d       = ARMED;
            err_short_d   = 1'b0;
            err_timeout_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs and buffer write strobe
  always_comb begin
    sbf         = (state_q == REQ);
    busy        = (state_q != IDLE);
    frame_ready = (state_q == DONE);
    // A byte completes on every 8th sampled bit; cd in that cycle wins.
    wr_en       = (state_q == SHIFT) && !bus.cd && (bit_cnt_q[2:0] == 3'd7);
    wr_addr     = bit_cnt_q[BW-1:3];
    wr_data     = {shift_q, bus.sd};
  end

  assign bus.sbf         = sbf;
  assign bus.busy        = busy;
  assign bus.frame_ready = frame_ready;
  assign bus.trig_time   = trig_time_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.err_short   = err_short_q;
  assign bus.err_timeout = err_timeout_q;

endmodule

// File: doc/tsc_readout.md
Name: tsc_readout

Overview:
Downstream consumer of the TSC transient-capture core. After TSC flags a trigger (trd), tsc_readout latches trigtm and pulses sbf to request the sample buffer. It then deserialises the TSC bit stream on sd into a byte-addressable frame buffer, and uses cd to confirm the end of the frame. A host reads the completed frame through a simple synchronous read port and acknowledges it to re-arm the block.

Parameters:
BUF_BYTES, 32, bytes per TSC frame (power of 2, 2..256)
START_LAT, 2, clk cycles from sbf sampled high to first data bit on sd (1..15)
CD_TIMEOUT, 64, max cycles after last bit to wait for cd before flagging timeout

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
arm  in  1  host pulse: enable capture of next trigger
trd  in  1  TSC trigger-detected flag
trigtm  in  32  TSC trigger timestamp, valid while trd high
sd  in  1  TSC serial data, MSB of byte 0 first
cd  in  1  TSC transmission-complete flag
sbf  out  1  send-buffer request to TSC, one-cycle pulse
frame_ready  out  1  frame buffer holds a complete, valid frame
trig_time  out  32  latched trigtm of the current frame
rd_addr  in  log2(BUF_BYTES)  host read byte address
rd_data  out  8  byte at rd_addr, registered, 1-cycle latency
frame_ack  in  1  host pulse: frame consumed, return to IDLE
err_short  out  1  sticky: cd seen before all bits received
err_timeout  out  1  sticky: cd not seen within CD_TIMEOUT after last bit
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE. sbf, frame_ready, err_short, err_timeout and busy are 0; trig_time and rd_data are 0; bit counter and timers are 0. Buffer contents are don't-care. Reset mid-frame aborts immediately, with no sbf re-issue.
- States: IDLE, ARMED, REQ, LAT, SHIFT, WAIT_CD, DONE.
- IDLE: arm=1 -> ARMED and clear both error flags. All other inputs are ignored.
- ARMED: trd rising edge (trd=1 this cycle, 0 the previous cycle) -> latch trigtm into trig_time, go to REQ. A trd already high on entry to ARMED is not a trigger.
- REQ: sbf=1 for exactly this one cycle; load the latency counter with START_LAT-1; go to LAT.
- LAT: count down. At 0, go to SHIFT. The first sd bit is sampled in the first SHIFT cycle, exactly START_LAT cycles after the REQ cycle.
- SHIFT: sample sd every cycle and shift MSB-first into an 8-bit register. After every 8th bit, write the byte to buffer[bit_cnt>>3]. The bit counter runs 0..8*BUF_BYTES-1.
  - cd=1 before the final bit: set err_short, go to DONE. Partial bytes are discarded, and frame_ready is still asserted so the host can inspect the frame.
  - After the final bit: go to WAIT_CD.
- WAIT_CD:
  - cd=1 -> DONE (cd high in the cycle after the last bit is legal).
  - Timer reaches CD_TIMEOUT without cd -> set err_timeout, go to DONE.
- DONE: frame_ready=1. Buffer and trig_time are frozen. New trd/cd activity is ignored.
  - frame_ack=1 -> frame_ready=0, go to IDLE.
  - arm and frame_ack in the same cycle -> go directly to ARMED, with errors cleared.
- Read port: rd_data <= buffer[rd_addr] every cycle, regardless of state. Reads during SHIFT return possibly stale bytes; the host must wait for frame_ready.
- Ignored inputs: arm outside IDLE/DONE is ignored. frame_ack outside DONE is ignored.
- Error flags hold until the next accepted arm, or until reset.

Test Plan:
- Nominal frame: reset, arm, trd rise with trigtm=32'h0000_1234. Require sbf pulse 1 cycle later and trig_time=0x1234. Drive 256 bits encoding bytes 0x00..0x1F from cycle REQ+2, then cd in the next cycle. Require frame_ready=1, rd_addr=5 -> rd_data=0x05 one cycle later, both errors=0.
- Short frame: as nominal, but assert cd after 100 bits. Require err_short=1, frame_ready=1, and bytes 0..11 correct.
- Timeout: send all 256 bits, hold cd=0. Require err_timeout=1 and frame_ready=1 exactly 64 cycles after the last bit.
- Trigger gating: trd pulses while in IDLE, and trd held high at arm, produce no sbf. The first true rising edge after arm produces exactly one sbf.
- Reset mid-SHIFT: assert reset low at bit 40. Require state=IDLE and all outputs 0 next cycle. A subsequent arm plus trigger yields a correct full frame.
- Ack/re-arm: in DONE, pulse arm and frame_ack together. Require frame_ready=0, busy=1 (ARMED), errors cleared, and the next trd captured normally.
